eth_port_switch: RTL and testbench
==================================

# eth_port_switch

Parametrised Ethernet AXI-Stream port switch between the RISC-V core's single Ethernet stream pair and PORTS MAC/QSFP channels in the Ethernet subsystem. It generalises the current one-port, point-to-point hookup. TX packets are steered to a software-selected port and dropped if that link is down. RX packets from all ports are merged by packet-atomic round-robin arbitration. The block runs entirely in the Ethernet GT user clock domain.

## Interface
Parameters:
- PORTS, 2, number of MAC channels (1..8)
- DATA_W, 64, stream data width; KEEP_W = DATA_W/8
- LINK_BIT, 0, bit of each 16-bit per-port status word that means "link up"
- SEL_W, 3, width of the port-select input (must cover PORTS-1)

Ports (per-port buses are flattened, port i at slice i):
- clock  in  1  Ethernet GT user clock; the only clock
- resetn  in  1  asynchronous, active-low reset
- tx_port_sel  in  SEL_W  destination port, sampled at TX packet start
- s_tx_tdata/tkeep/tlast/tuser/tvalid  in  DATA_W/KEEP_W/1/1/1  TX stream from core
- s_tx_tready  out  1
- m_tx_tdata/tkeep/tlast/tuser/tvalid  out  PORTS×(DATA_W/KEEP_W/1/1/1)  TX streams to MACs
- m_tx_tready  in  PORTS
- s_rx_tdata/tkeep/tlast/tuser/tvalid  in  PORTS×(DATA_W/KEEP_W/1/1/1)  RX streams from MACs
- s_rx_tready  out  PORTS
- m_rx_tdata/tkeep/tlast/tuser/tvalid  out  DATA_W/KEEP_W/1/1/1  merged RX stream to core
- m_rx_tready  in  1
- port_status  in  PORTS×16  per-port MAC status words
- link_up  out  PORTS  registered link bits
- rx_port  out  SEL_W  source port of the RX packet in flight
- tx_drop_count  out  16  saturating count of dropped TX packets

## Operation
- link_up[i] <= port_status[i*16+LINK_BIT], registered every cycle.
- TX FSM states: T_IDLE, T_FWD, T_DROP.
  - T_IDLE: s_tx_tready=0. When s_tx_tvalid=1, latch tx_cur=tx_port_sel.
    - If tx_cur<PORTS and link_up[tx_cur]=1, go to T_FWD.
    - Otherwise go to T_DROP.
  - T_FWD: m_tx_*[tx_cur] is a combinational copy of s_tx_*. s_tx_tready=m_tx_tready[tx_cur]. Every other m_tx_tvalid is 0. On a tlast handshake, go to T_IDLE.
  - T_DROP: s_tx_tready=1 and every m_tx_tvalid is 0. On a tlast handshake, tx_drop_count increments (saturating at 0xFFFF) and the FSM goes to T_IDLE.
  - A link drop during T_FWD has no effect until tlast. The packet completes to the MAC.
- RX FSM states: R_IDLE, R_GRANT. Pointer rr_ptr holds the last served port.
  - R_IDLE: search ports rr_ptr+1, rr_ptr+2, … (mod PORTS) for the first port with s_rx_tvalid=1 and link_up=1. If found, latch grant and rx_port, and go to R_GRANT.
  - R_GRANT: m_rx_* is a copy of s_rx_*[grant]. s_rx_tready[grant]=m_rx_tready. On a tlast handshake, set rr_ptr=grant and go to R_IDLE.
  - Non-granted ports with link_up=1 get s_rx_tready=0, so they are backpressured.
  - Ports with link_up=0 that are not granted get s_rx_tready=1, so their data is flushed.
  - A granted port stays granted until tlast, even if its link drops.
- tuser passes through unmodified in both directions.

## Timing
- Reset (asynchronous assert, synchronous-safe release) puts both FSMs in their IDLE states and sets:
  - tx_cur=0, grant=0, rx_port=0, rr_ptr=PORTS-1 (port 0 is served first), tx_drop_count=0, link_up=0.
  - s_tx_tready=0, all m_tx_tvalid=0, m_rx_tvalid=0.
  - All s_rx_tready=1, because every link reads down.
- Reset mid-packet abandons the packet. There is no recovery beat, and the remaining beats of the old packet are treated as a new packet.
- One bubble cycle per packet (the IDLE state) in each direction. The data path inside a packet has zero latency, with full throughput of one beat per cycle.
- link_up lags port_status by 1 cycle. An RX or TX decision uses link_up as it stands in the IDLE cycle.
- A TX tlast handshake and a new s_tx_tvalid may occur in the same cycle. The new packet is evaluated in the following T_IDLE cycle, and its tx_port_sel is sampled then.
- Single-beat packets (tvalid and tlast on the first beat) complete in 2 cycles: IDLE plus one data beat.
- PORTS=1: arbitration degenerates to port 0. tx_port_sel values ≥1 drop the packet.

## Test plan
- PORTS=2, both links up, tx_port_sel=1, 4-beat packet (tlast on beat 4) → beats appear only on m_tx port 1; m_tx_tvalid[0] stays 0; s_tx_tready deasserts for exactly 1 cycle before the next packet.
- Link 1 down, tx_port_sel=1, 3 packets → all accepted with no m_tx_tvalid on any port; tx_drop_count=3. Then tx_port_sel=5 → tx_drop_count=4.
- Both RX ports continuously valid with 2-beat packets → m_rx sequence comes from ports 0,1,0,1 (rx_port alternates); no packet interleaving.
- Port 0 drops its link mid-grant during a 6-beat RX packet → all 6 beats are delivered. Afterwards port 0 is flushed (s_rx_tready[0]=1) and only port 1 is granted.
- m_rx_tready held low 10 cycles mid-packet → the granted port is stalled and the other port's s_rx_tready stays 0; no beats lost or duplicated.
- Assert resetn=0 mid-TX packet → all outputs take their reset values asynchronously; tx_drop_count=0; the first post-reset packet routes correctly.

Source files
------------

// File: rtl/eth_port_switch.sv
// Ethernet stream switch: core TX steered to a selected MAC port (dropped if link down); MAC RX merged by packet-atomic round robin.
// Zero-latency data path inside a packet, one idle cycle per packet per direction; backpressure passes straight through the selected path.
module eth_port_switch #(
  parameter  int PORTS    = 2,
  parameter  int DATA_W   = 64,
  localparam int KEEP_W   = DATA_W / 8,
  parameter  int LINK_BIT = 0,
  parameter  int SEL_W    = 3
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [SEL_W-1:0]           tx_port_sel,
  input  logic [DATA_W-1:0]          s_tx_tdata,
  input  logic [KEEP_W-1:0]          s_tx_tkeep,
  input  logic                       s_tx_tlast,
  input  logic                       s_tx_tuser,
  input  logic                       s_tx_tvalid,
  output logic                       s_tx_tready,
  output logic [PORTS*DATA_W-1:0]    m_tx_tdata,
  output logic [PORTS*KEEP_W-1:0]    m_tx_tkeep,
  output logic [PORTS-1:0]           m_tx_tlast,
  output logic [PORTS-1:0]           m_tx_tuser,
  output logic [PORTS-1:0]           m_tx_tvalid,
  input  logic [PORTS-1:0]           m_tx_tready,
  input  logic [PORTS*DATA_W-1:0]    s_rx_tdata,
  input  logic [PORTS*KEEP_W-1:0]    s_rx_tkeep,
  input  logic [PORTS-1:0]           s_rx_tlast,
  input  logic [PORTS-1:0]           s_rx_tuser,
  input  logic [PORTS-1:0]           s_rx_tvalid,
  output logic [PORTS-1:0]           s_rx_tready,
  output logic [DATA_W-1:0]          m_rx_tdata,
  output logic [KEEP_W-1:0]          m_rx_tkeep,
  output logic                       m_rx_tlast,
  output logic                       m_rx_tuser,
  output logic                       m_rx_tvalid,
  input  logic                       m_rx_tready,
  input  logic [PORTS*16-1:0]        port_status,
  output logic [PORTS-1:0]           link_up,
  output logic [SEL_W-1:0]           rx_port,
  output logic [15:0]                tx_drop_count
);

  typedef enum logic [1:0] {T_IDLE, T_FWD, T_DROP} tx_state_t;
  typedef enum logic {R_IDLE, R_GRANT} rx_state_t;

  tx_state_t         r_tx_state, w_tx_next;
  rx_state_t         r_rx_state, w_rx_next;
  logic [PORTS-1:0]  r_link_up;
  logic [SEL_W-1:0]  r_tx_cur;
  logic [15:0]       r_drop_cnt;
  logic [SEL_W-1:0]  r_grant;
  logic [SEL_W-1:0]  r_rx_port;
  logic [SEL_W-1:0]  r_rr_ptr;
  logic              w_sel_ok;
  logic [PORTS-1:0]  w_cand;
  logic              w_hi_found, w_lo_found, w_rx_found;
  logic [SEL_W-1:0]  w_hi_idx, w_lo_idx, w_rx_pick;
  logic              w_g_vld;
  logic              w_unused;

  assign link_up       = r_link_up;
  assign rx_port       = r_rx_port;
  assign tx_drop_count = r_drop_cnt;
  assign w_unused      = ^port_status;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_link_up <= '0;
    end else begin
      for (int i = 0; i < PORTS; i++) r_link_up[i] <= port_status[i*16+LINK_BIT];
    end
  end

  // ---------------- TX steering ----------------
  always_comb begin
    w_sel_ok = 1'b0;
    for (int i = 0; i < PORTS; i++)
      if (tx_port_sel == SEL_W'(i) && r_link_up[i]) w_sel_ok = 1'b1;
  end

  assign m_tx_tdata = {PORTS{s_tx_tdata}};
  assign m_tx_tkeep = {PORTS{s_tx_tkeep}};
  assign m_tx_tlast = {PORTS{s_tx_tlast}};
  assign m_tx_tuser = {PORTS{s_tx_tuser}};

  always_comb begin
    w_tx_next   = r_tx_state;
    s_tx_tready = 1'b0;
    m_tx_tvalid = '0;
    case (r_tx_state)
      T_IDLE: begin
        if (s_tx_tvalid) w_tx_next = w_sel_ok ? T_FWD : T_DROP;
      end
      T_FWD: begin
        for (int i = 0; i < PORTS; i++) begin
          if (r_tx_cur == SEL_W'(i)) begin
            m_tx_tvalid[i] = s_tx_tvalid;
            s_tx_tready    = m_tx_tready[i];
          end
        end
        if (s_tx_tvalid && s_tx_tready && s_tx_tlast) w_tx_next = T_IDLE;
      end
      T_DROP: begin
        s_tx_tready = 1'b1;
        if (s_tx_tvalid && s_tx_tlast) w_tx_next = T_IDLE;
      end
      default: w_tx_next = T_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_tx_state <= T_IDLE;
      r_tx_cur   <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_tx_state <= w_tx_next;
      if (r_tx_state == T_IDLE && s_tx_tvalid) r_tx_cur <= tx_port_sel;
      if (r_tx_state == T_DROP && s_tx_tvalid && s_tx_tlast && r_drop_cnt != 16'hFFFF)
        r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  // ---------------- RX arbitration ----------------
  assign w_cand = s_rx_tvalid & r_link_up;

  // Ports above the last served one win first; otherwise wrap to the lowest candidate.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int i = PORTS - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        if (SEL_W'(i) > r_rr_ptr) begin
          w_hi_found = 1'b1;
          w_hi_idx   = SEL_W'(i);
        end else begin
          w_lo_found = 1'b1;
          w_lo_idx   = SEL_W'(i);
        end
      end
    end
  end

  assign w_rx_found = w_hi_found | w_lo_found;
  assign w_rx_pick  = w_hi_found ? w_hi_idx : w_lo_idx;

  always_comb begin
    m_rx_tdata = '0;
    m_rx_tkeep = '0;
    m_rx_tlast = 1'b0;
    m_rx_tuser = 1'b0;
    w_g_vld    = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      if (r_grant == SEL_W'(i)) begin
        m_rx_tdata = s_rx_tdata[i*DATA_W +: DATA_W];
        m_rx_tkeep = s_rx_tkeep[i*KEEP_W +: KEEP_W];
        m_rx_tlast = s_rx_tlast[i];
        m_rx_tuser = s_rx_tuser[i];
        w_g_vld    = s_rx_tvalid[i];
      end
    end
    m_rx_tvalid = (r_rx_state == R_GRANT) && w_g_vld;
  end

  // Link-down ports are drained so a dead MAC cannot wedge its FIFO.
  always_comb begin
    s_rx_tready = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (r_rx_state == R_GRANT && r_grant == SEL_W'(i)) s_rx_tready[i] = m_rx_tready;
      else                                              s_rx_tready[i] = ~r_link_up[i];
    end
  end

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      R_IDLE:  if (w_rx_found) w_rx_next = R_GRANT;
      R_GRANT: if (m_rx_tvalid && m_rx_tready && m_rx_tlast) w_rx_next = R_IDLE;
      default: w_rx_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_rx_state <= R_IDLE;
      r_grant    <= '0;
      r_rx_port  <= '0;
      r_rr_ptr   <= SEL_W'(PORTS - 1);
    end else begin
      r_rx_state <= w_rx_next;
      if (r_rx_state == R_IDLE && w_rx_found) begin
        r_grant   <= w_rx_pick;
        r_rx_port <= w_rx_pick;
      end
      if (r_rx_state == R_GRANT && m_rx_tvalid && m_rx_tready && m_rx_tlast)
        r_rr_ptr <= r_grant;
    end
  end

endmodule

// File: tb/tb_eth_port_switch.sv
// Bench for eth_port_switch (PORTS=2): TX vector table, RX arbitration/flush/stall sequences, mid-packet reset.
module tb_eth_port_switch;
  localparam int PORTS = 2;
  localparam int DATA_W = 64;
  localparam int KEEP_W = 8;
  localparam int SEL_W = 3;

  logic                    clock = 1'b0;
  logic                    resetn = 1'b1;
  logic [SEL_W-1:0]        tx_port_sel = '0;
  logic [DATA_W-1:0]       s_tx_tdata = '0;
  logic [KEEP_W-1:0]       s_tx_tkeep = '1;
  logic                    s_tx_tlast = 1'b0;
  logic                    s_tx_tuser = 1'b0;
  logic                    s_tx_tvalid = 1'b0;
  logic                    s_tx_tready;
  logic [PORTS*DATA_W-1:0] m_tx_tdata;
  logic [PORTS*KEEP_W-1:0] m_tx_tkeep;
  logic [PORTS-1:0]        m_tx_tlast, m_tx_tuser, m_tx_tvalid;
  logic [PORTS-1:0]        m_tx_tready = '1;
  logic [PORTS*DATA_W-1:0] s_rx_tdata = '0;
  logic [PORTS*KEEP_W-1:0] s_rx_tkeep = '1;
  logic [PORTS-1:0]        s_rx_tlast = '0, s_rx_tuser = '0, s_rx_tvalid = '0;
  logic [PORTS-1:0]        s_rx_tready;
  logic [DATA_W-1:0]       m_rx_tdata;
  logic [KEEP_W-1:0]       m_rx_tkeep;
  logic                    m_rx_tlast, m_rx_tuser, m_rx_tvalid;
  logic                    m_rx_tready = 1'b1;
  logic [PORTS*16-1:0]     port_status = '0;
  logic [PORTS-1:0]        link_up;
  logic [SEL_W-1:0]        rx_port;
  logic [15:0]             tx_drop_count;

  always #5 clock = ~clock;

  eth_port_switch #(.PORTS(PORTS), .DATA_W(DATA_W), .LINK_BIT(0), .SEL_W(SEL_W)) dut (
    .clock(clock), .resetn(resetn), .tx_port_sel(tx_port_sel),
    .s_tx_tdata(s_tx_tdata), .s_tx_tkeep(s_tx_tkeep), .s_tx_tlast(s_tx_tlast),
    .s_tx_tuser(s_tx_tuser), .s_tx_tvalid(s_tx_tvalid), .s_tx_tready(s_tx_tready),
    .m_tx_tdata(m_tx_tdata), .m_tx_tkeep(m_tx_tkeep), .m_tx_tlast(m_tx_tlast),
    .m_tx_tuser(m_tx_tuser), .m_tx_tvalid(m_tx_tvalid), .m_tx_tready(m_tx_tready),
    .s_rx_tdata(s_rx_tdata), .s_rx_tkeep(s_rx_tkeep), .s_rx_tlast(s_rx_tlast),
    .s_rx_tuser(s_rx_tuser), .s_rx_tvalid(s_rx_tvalid), .s_rx_tready(s_rx_tready),
    .m_rx_tdata(m_rx_tdata), .m_rx_tkeep(m_rx_tkeep), .m_rx_tlast(m_rx_tlast),
    .m_rx_tuser(m_rx_tuser), .m_rx_tvalid(m_rx_tvalid), .m_rx_tready(m_rx_tready),
    .port_status(port_status), .link_up(link_up), .rx_port(rx_port),
    .tx_drop_count(tx_drop_count)
  );

  typedef struct { int port; logic [63:0] data; logic last; logic user; } exp_t;
  typedef struct { logic [63:0] data; logic last; logic user; } beat_t;
  typedef struct { logic [2:0] sel; logic [1:0] link; int beats; bit fwd; int port; logic [15:0] drops; } tv_t;

  exp_t  tx_exp[$];
  exp_t  rx_exp[$];
  beat_t src0[$];
  beat_t src1[$];
  tv_t   tv[8];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic set_links(input logic [1:0] l);
    port_status = '0;
    port_status[0]  = l[0];
    port_status[16] = l[1];
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clock);
      for (int p = 0; p < PORTS; p++) begin
        if (m_tx_tvalid[p] && m_tx_tready[p]) begin
          if (tx_exp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected_beat: port %0d data %0h, required no beat", p, m_tx_tdata[p*DATA_W +: DATA_W]);
          end else begin
            e = tx_exp.pop_front();
            chk("tx_port", 64'(p), 64'(e.port));
            chk("tx_data", m_tx_tdata[p*DATA_W +: DATA_W], e.data);
            chk("tx_last", 64'(m_tx_tlast[p]), 64'(e.last));
            chk("tx_user", 64'(m_tx_tuser[p]), 64'(e.user));
            chk("tx_keep", 64'(m_tx_tkeep[p*KEEP_W +: KEEP_W]), 64'hFF);
          end
        end
      end
      if (m_rx_tvalid && m_rx_tready) begin
        if (rx_exp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected_beat: data %0h, required no beat", m_rx_tdata);
        end else begin
          e = rx_exp.pop_front();
          chk("rx_port", 64'(rx_port), 64'(e.port));
          chk("rx_data", m_rx_tdata, e.data);
          chk("rx_last", 64'(m_rx_tlast), 64'(e.last));
          chk("rx_user", 64'(m_rx_tuser), 64'(e.user));
          chk("rx_keep", 64'(m_rx_tkeep), 64'hFF);
        end
      end
    end
  endtask

  // MAC-side RX sources: a beat leaves its queue only after a handshake.
  task automatic rx_driver();
    bit hs0, hs1;
    beat_t b;
    forever begin
      @(negedge clock);
      hs0 = s_rx_tvalid[0] && s_rx_tready[0];
      hs1 = s_rx_tvalid[1] && s_rx_tready[1];
      @(posedge clock);
      #1;
      if (hs0 && src0.size() > 0) b = src0.pop_front();
      if (hs1 && src1.size() > 0) b = src1.pop_front();
      #1;
      s_rx_tvalid[0] = (src0.size() > 0);
      if (src0.size() > 0) begin
        s_rx_tdata[63:0] = src0[0].data;
        s_rx_tlast[0] = src0[0].last;
        s_rx_tuser[0] = src0[0].user;
      end
      s_rx_tvalid[1] = (src1.size() > 0);
      if (src1.size() > 0) begin
        s_rx_tdata[127:64] = src1[0].data;
        s_rx_tlast[1] = src1[0].last;
        s_rx_tuser[1] = src1[0].user;
      end
    end
  endtask

  task automatic rx_pkt(input int port, input int pkt, input int n, input bit expect_out);
    beat_t b;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      b.data = 64'(port * 65536 + pkt * 256 + i);
      b.last = (i == n - 1);
      b.user = i[0];
      if (port == 0) src0.push_back(b);
      else           src1.push_back(b);
      if (expect_out) begin
        e.port = port; e.data = b.data; e.last = b.last; e.user = b.user;
        rx_exp.push_back(e);
      end
    end
  endtask

  task automatic wait_rx_drain(input int limit);
    int w = 0;
    while ((rx_exp.size() != 0 || src0.size() != 0 || src1.size() != 0) && w < limit) begin
      cycles(1);
      w++;
    end
    chk("rx_drain_timeout", 64'(w >= limit), 64'd0);
  endtask

  task automatic tx_beat(input logic [SEL_W-1:0] sel, input logic [63:0] d, input logic last,
                         input logic user, input bit fwd, input int port, input int exp_wait);
    int w = 0;
    exp_t e;
    tx_port_sel = sel;
    s_tx_tdata  = d;
    s_tx_tlast  = last;
    s_tx_tuser  = user;
    s_tx_tvalid = 1'b1;
    if (fwd) begin
      e.port = port; e.data = d; e.last = last; e.user = user;
      tx_exp.push_back(e);
    end
    @(negedge clock);
    while (!s_tx_tready && w < 40) begin
      @(negedge clock);
      w++;
    end
    chk("tx_ready_wait_cycles", 64'(w), 64'(exp_wait));
    @(posedge clock);
    #1;
  endtask

  task automatic tx_packet(input logic [SEL_W-1:0] sel, input int tag, input int n, input bit fwd, input int port);
    for (int b = 0; b < n; b++)
      tx_beat(sel, 64'(tag * 256 + b), (b == n - 1), b[0], fwd, port, (b == 0) ? 1 : 0);
    s_tx_tvalid = 1'b0;
  endtask

  initial begin
    fork
      monitor();
      rx_driver();
      begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
      end
    join_none

    tv[0] = '{3'd1, 2'b11, 4, 1'b1, 1, 16'd0};
    tv[1] = '{3'd0, 2'b11, 1, 1'b1, 0, 16'd0};
    tv[2] = '{3'd1, 2'b01, 3, 1'b0, 0, 16'd1};
    tv[3] = '{3'd1, 2'b01, 3, 1'b0, 0, 16'd2};
    tv[4] = '{3'd1, 2'b01, 2, 1'b0, 0, 16'd3};
    tv[5] = '{3'd5, 2'b11, 2, 1'b0, 0, 16'd4};
    tv[6] = '{3'd0, 2'b10, 2, 1'b0, 0, 16'd5};
    tv[7] = '{3'd1, 2'b10, 3, 1'b1, 1, 16'd5};

    // Reset values, with links reported up to show link_up held low.
    set_links(2'b11);
    #1 resetn = 1'b0;
    #2;
    chk("rst_s_tx_tready", 64'(s_tx_tready), 64'd0);
    chk("rst_m_tx_tvalid", 64'(m_tx_tvalid), 64'd0);
    chk("rst_m_rx_tvalid", 64'(m_rx_tvalid), 64'd0);
    chk("rst_link_up", 64'(link_up), 64'd0);
    chk("rst_s_rx_tready", 64'(s_rx_tready), 64'h3);
    chk("rst_drop_count", 64'(tx_drop_count), 64'd0);
    #9 resetn = 1'b1;

    for (int i = 0; i < 8; i++) begin
      set_links(tv[i].link);
      cycles(2);
      tx_packet(tv[i].sel, 16 + i, tv[i].beats, tv[i].fwd, tv[i].port);
      chk("tx_drop_count", 64'(tx_drop_count), 64'(tv[i].drops));
    end

    // Back-to-back packets: exactly one not-ready cycle before each.
    set_links(2'b11);
    cycles(2);
    tx_packet(3'd1, 40, 4, 1'b1, 1);
    tx_packet(3'd1, 41, 4, 1'b1, 1);
    chk("tx_b2b_drained", 64'(tx_exp.size()), 64'd0);

    // RX round robin: both ports continuously valid.
    rx_pkt(0, 0, 2, 1'b1);
    rx_pkt(1, 0, 2, 1'b1);
    rx_pkt(0, 1, 2, 1'b1);
    rx_pkt(1, 1, 2, 1'b1);
    wait_rx_drain(100);

    // Port 0 link drops mid-grant; its packet still completes.
    rx_pkt(0, 2, 6, 1'b1);
    rx_pkt(1, 2, 2, 1'b1);
    rx_pkt(1, 3, 2, 1'b1);
    cycles(3);
    set_links(2'b10);
    wait_rx_drain(100);
    chk("rx_link0_down", 64'(link_up), 64'h2);
    rx_pkt(0, 9, 2, 1'b0);
    @(negedge clock);
    chk("rx_flush_ready0", 64'(s_rx_tready[0]), 64'd1);
    chk("rx_flush_no_valid", 64'(m_rx_tvalid), 64'd0);
    cycles(1);
    rx_pkt(1, 5, 2, 1'b1);
    wait_rx_drain(100);

    // Downstream stall mid-packet.
    set_links(2'b11);
    cycles(2);
    rx_pkt(0, 4, 4, 1'b1);
    rx_pkt(1, 4, 2, 1'b1);
    cycles(2);
    m_rx_tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("rx_stall_ready", 64'(s_rx_tready), 64'd0);
      chk("rx_stall_valid", 64'(m_rx_tvalid), 64'd1);
      cycles(1);
    end
    m_rx_tready = 1'b1;
    wait_rx_drain(100);

    // Reset in the middle of a forwarded TX packet.
    tx_beat(3'd1, 64'h5000, 1'b0, 1'b0, 1'b1, 1, 1);
    tx_beat(3'd1, 64'h5001, 1'b0, 1'b1, 1'b1, 1, 0);
    s_tx_tdata = 64'h5002;
    #1 resetn = 1'b0;
    #1;
    chk("mid_rst_s_tx_tready", 64'(s_tx_tready), 64'd0);
    chk("mid_rst_m_tx_tvalid", 64'(m_tx_tvalid), 64'd0);
    chk("mid_rst_link_up", 64'(link_up), 64'd0);
    chk("mid_rst_drop_count", 64'(tx_drop_count), 64'd0);
    chk("mid_rst_rx_port", 64'(rx_port), 64'd0);
    chk("mid_rst_s_rx_tready", 64'(s_rx_tready), 64'h3);
    s_tx_tvalid = 1'b0;
    cycles(1);
    resetn = 1'b1;
    cycles(2);
    chk("post_rst_link_up", 64'(link_up), 64'h3);
    tx_packet(3'd0, 60, 3, 1'b1, 0);
    chk("post_rst_drop_count", 64'(tx_drop_count), 64'd0);

    cycles(2);
    chk("tx_scoreboard_empty", 64'(tx_exp.size()), 64'd0);
    chk("rx_scoreboard_empty", 64'(rx_exp.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
